seq_alu: RTL and testbench

Parametrised, handshaked successor to the combinational simple ALU.
- Keeps the same 3-bit command set and the X/Y result pair.
- Adds registered operands and results, valid/ready flow control on input and output, and an iterative one-bit-per-cycle shifter. Shifts therefore have data-dependent latency.
- Sits between an operand-issue stage and a result consumer. Holds one operation in flight.

---
 rtl/seq_alu.sv | 99 +++++++++
 tb/tb_seq_alu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered results and a one-bit-per-cycle shifter; define SEQ_ALU_BARREL_SHIFT_EN for single-cycle shifts
module seq_alu #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic             busy
);
    localparam logic [2:0] op_add = 3'd1;
    localparam logic [2:0] op_sub = 3'd2;
    localparam logic [2:0] op_sll = 3'd3;
    localparam logic [2:0] op_slr = 3'd4;
    localparam logic [2:0] op_and = 3'd5;
    localparam logic [2:0] op_or  = 3'd6;
    localparam logic [2:0] op_xor = 3'd7;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic acc;
    logic [CNT_W-1:0] s;
    logic [WIDTH-1:0] rx, ry;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
    logic is_shift, dir;
    logic [CNT_W-1:0] cnt;
    assign is_shift = cmd == op_sll || cmd == op_slr;
`endif
    // WIDTH is a power of two, so any set bit at or above log2(WIDTH) means B >= WIDTH
    assign s = |B[WIDTH-1:CNT_W-1] ? CNT_W'(WIDTH) : B[CNT_W-1:0];
    // Result produced at accept; iterative shifts start from X=A, Y=0
    always_comb begin
        rx = A;
        ry = '0;
        case (cmd)
            op_add: {ry[0], rx} = {1'b0, A} + {1'b0, B};
            op_sub: {ry[0], rx} = {1'b0, A} - {1'b0, B};
            op_and: rx = A & B;
            op_or:  rx = A | B;
            op_xor: rx = A ^ B;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
            op_sll: {ry, rx} = {{WIDTH{1'b0}}, A} << s;
            op_slr: {rx, ry} = {A, {WIDTH{1'b0}}} >> s;
`endif
            default: ;
        endcase
    end
    // Handshake outputs and next state; DONE with out_ready may accept the next op in the same cycle
    always_comb begin
        in_ready = state == IDLE || (state == DONE && out_ready);
        out_valid = state == DONE;
        acc = in_valid && in_ready;
        state_nx = state;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
        busy = 1'b0;
        if (acc) state_nx = DONE;
        else if (state == DONE && out_ready) state_nx = IDLE;
`else
        busy = state == SHIFT;
        if (acc) state_nx = (is_shift && s != '0) ? SHIFT : DONE;
        else if (state == SHIFT) state_nx = (cnt == CNT_W'(1)) ? DONE : SHIFT;
        else if (state == DONE && out_ready) state_nx = IDLE;
`endif
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // Result registers: load at accept, then shift {X,Y} one bit per SHIFT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X <= '0;
            Y <= '0;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            cnt <= '0;
            dir <= 1'b0;
`endif
        end else if (acc) begin
            X <= rx;
            Y <= ry;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            cnt <= is_shift ? s : '0;
            dir <= cmd == op_slr;
        end else if (state == SHIFT) begin
            if (dir) {X, Y} <= {X, Y} >> 1;
            else {Y, X} <= {Y, X} << 1;
            cnt <= cnt - CNT_W'(1);
`endif
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu covering arithmetic, shifts, backpressure, back-to-back issue and reset
module tb_seq_alu;
    localparam int W = 64;
    localparam logic [2:0] c_nop = 3'd0;
    localparam logic [2:0] c_add = 3'd1;
    localparam logic [2:0] c_sub = 3'd2;
    localparam logic [2:0] c_sll = 3'd3;
    localparam logic [2:0] c_slr = 3'd4;
    localparam logic [2:0] c_and = 3'd5;
    localparam logic [2:0] c_or  = 3'd6;
    localparam logic [2:0] c_xor = 3'd7;
    typedef struct {logic [2:0] c; logic [W-1:0] a, b, x, y;} op_t;
    typedef struct {logic [W-1:0] x, y;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0] cmd = '0;
    logic in_ready, out_valid, busy;
    logic [W-1:0] X, Y;
    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cmd(cmd), .out_valid(out_valid), .out_ready(out_ready),
        .X(X), .Y(Y), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int lat_of(input logic [2:0] c, input logic [W-1:0] b);
`ifdef SEQ_ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (c != c_sll && c != c_slr) return 1;
        return (b >= 64'(W) ? W : int'(b)) + 1;
`endif
    endfunction

    function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] w;
        int s;
        s = b >= 64'(W) ? W : int'(b);
        w = '0;
        e.x = a;
        e.y = '0;
        case (c)
            c_add: begin w = {{W{1'b0}}, a} + {{W{1'b0}}, b}; e.x = w[W-1:0]; e.y[0] = w[W]; end
            c_sub: begin e.x = a - b; e.y[0] = a < b; end
            c_sll: begin
                for (int i = 0; i < W; i++) w[i + s] = a[i];
                e.x = w[W-1:0];
                e.y = w[2*W-1:W];
            end
            c_slr: begin
                for (int i = 0; i < W; i++) w[i + W - s] = a[i];
                e.x = w[2*W-1:W];
                e.y = w[W-1:0];
            end
            c_and: e.x = a & b;
            c_or:  e.x = a | b;
            c_xor: e.x = a ^ b;
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input op_t o);
        cmd = o.c;
        A = o.a;
        B = o.b;
        in_valid = 1'b1;
        sb.push_back('{o.x, o.y});
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        cmd = 3'($urandom);
    endtask

    task automatic wait_out(output int lat, output int bz);
        lat = 1;
        bz = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bz++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (X !== '0 || Y !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: X=%h Y=%h out_valid=%b busy=%b, expected all zero", X, Y, out_valid, busy);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_arith;
        op_t t[8] = '{
            '{c_add, 64'd10, 64'd30, 64'd40, 64'd0},
            '{c_add, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd1},
            '{c_sub, 64'd80, 64'd160, 64'hFFFF_FFFF_FFFF_FFB0, 64'd1},
            '{c_sub, 64'd160, 64'd80, 64'd80, 64'd0},
            '{c_nop, 64'd123, 64'd456, 64'd123, 64'd0},
            '{c_and, 64'hF0F0, 64'hFF00, 64'hF000, 64'd0},
            '{c_or, 64'hF0F0, 64'hFF00, 64'hFFF0, 64'd0},
            '{c_xor, 64'hF0F0, 64'hFF00, 64'h0FF0, 64'd0}
        };
        int lat, bz;
        exp_t e;
        foreach (t[i]) begin
            issue(t[i]);
            wait_out(lat, bz);
            e = sb.pop_front();
            tests++;
            if (X !== e.x || Y !== e.y || lat !== 1 || bz !== 0) begin
                fails++;
                $display("FAIL arith[%0d]: X=%h Y=%h lat=%0d busy_cycles=%0d, expected X=%h Y=%h lat=1 busy_cycles=0", i, X, Y, lat, bz, e.x, e.y);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain: out_valid=%b in_ready=%b, expected 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_shift;
        op_t t[8] = '{
            '{c_sll, 64'd2, 64'd5, 64'd64, 64'd0},
            '{c_sll, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'd1},
            '{c_sll, 64'd5, 64'd200, 64'd0, 64'd5},
            '{c_sll, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 64'd0},
            '{c_slr, 64'd15, 64'd3, 64'd1, 64'hE000_0000_0000_0000},
            '{c_slr, 64'hABCD, 64'd0, 64'hABCD, 64'd0},
            '{c_slr, 64'h8000_0000_0000_0001, 64'd64, 64'd0, 64'h8000_0000_0000_0001},
            '{c_sll, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hDEAD}
        };
        int lat, bz, le;
        exp_t e;
        foreach (t[i]) begin
            issue(t[i]);
            wait_out(lat, bz);
            e = sb.pop_front();
            le = lat_of(t[i].c, t[i].b);
            tests++;
            if (X !== e.x || Y !== e.y || lat !== le || bz !== le - 1) begin
                fails++;
                $display("FAIL shift[%0d]: X=%h Y=%h lat=%0d busy_cycles=%0d, expected X=%h Y=%h lat=%0d busy_cycles=%0d", i, X, Y, lat, bz, e.x, e.y, le, le - 1);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat, bz;
        exp_t e;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue('{c_and, 64'd36, 64'd20, 64'd4, 64'd0});
        wait_out(lat, bz);
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || X !== e.x || Y !== e.y) begin
                fails++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b X=%h Y=%h, expected 1 0 X=%h Y=%h", k, out_valid, in_ready, X, Y, e.x, e.y);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_ready: in_ready=%b, expected 1", in_ready);
        end
        issue('{c_or, 64'd31, 64'd32, 64'd63, 64'd0});
        wait_out(lat, bz);
        e = sb.pop_front();
        tests++;
        if (X !== e.x || Y !== e.y || lat !== 1) begin
            fails++;
            $display("FAIL same_cycle_issue: X=%h Y=%h lat=%0d, expected X=%h Y=%h lat=1", X, Y, lat, e.x, e.y);
        end
    endtask

    task automatic test_back_to_back;
        op_t o;
        exp_t e, m;
        int lat, bz, le;
        for (int n = 0; n < 40; n++) begin
            o.c = 3'($urandom);
            o.a = {$urandom, $urandom};
            o.b = (o.c == c_sll || o.c == c_slr) && $urandom_range(0, 3) != 0 ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
            m = model(o.c, o.a, o.b);
            o.x = m.x;
            o.y = m.y;
            issue(o);
            wait_out(lat, bz);
            e = sb.pop_front();
            le = lat_of(o.c, o.b);
            tests++;
            if (X !== e.x || Y !== e.y || lat !== le) begin
                fails++;
                $display("FAIL b2b[%0d] cmd=%0d A=%h B=%h: X=%h Y=%h lat=%0d, expected X=%h Y=%h lat=%0d", n, o.c, o.a, o.b, X, Y, lat, e.x, e.y, le);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat, bz;
        exp_t e;
        issue('{c_sll, 64'd1, 64'd40, 64'd0, 64'd0});
        repeat (9) begin
            @(posedge clk);
            #1;
        end
`ifndef SEQ_ALU_BARREL_SHIFT_EN
        tests++;
        if (busy !== 1'b1 || X !== 64'd512) begin
            fails++;
            $display("FAIL mid_shift: busy=%b X=%h, expected 1 and %h", busy, X, 64'd512);
        end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        tests++;
        if (X !== '0 || Y !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: X=%h Y=%h out_valid=%b busy=%b, expected all zero", X, Y, out_valid, busy);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b, expected 1 and 0", in_ready, out_valid);
        end
        issue('{c_xor, 64'd255, 64'd126, 64'd129, 64'd0});
        wait_out(lat, bz);
        e = sb.pop_front();
        tests++;
        if (X !== e.x || Y !== e.y || lat !== 1) begin
            fails++;
            $display("FAIL post_reset_xor: X=%h Y=%h lat=%0d, expected X=%h Y=%h lat=1", X, Y, lat, e.x, e.y);
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_shift;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
